// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for a multicycle MIPS datapath (FETCH/DECODE/EXEC/MEM/WB).
// One instruction is in flight at a time. A shared ALU and a single unified memory port are used.
// Memory states wait for mem_ready. A wait that runs past WAIT_LIMIT cycles raises bus_error and
// abandons the instruction. Retired instructions are counted in instr_count.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   opcode              IR[31:26], stable from DECODE until the instruction ends
//   zero                ALU zero flag; consumed by the datapath together with pc_write_cond
//   mem_ready           memory read data valid / write accepted this cycle
//   pc_write .. pc_source   datapath control (see per-state decode below)
//   state               current state code (debug)
//   illegal_op          1-cycle pulse on an unknown opcode in DECODE
//   bus_error           1-cycle pulse when a memory wait times out
//   instr_done          1-cycle pulse when an instruction retires
//   instr_count         retired-instruction count, wraps modulo 2^CNT_W
//
// Control outputs are decoded combinationally from the state register. They cannot be
// registered because ir_write/pc_write/instr_done/bus_error depend on mem_ready in the same cycle.
module multicycle_control_fsm #(
    parameter int unsigned WAIT_LIMIT = 255,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             bus_error,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StIExec   = 4'd10,
        StIWb     = 4'd11
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q;
    logic       timeout;
    logic       mem_state;

    // The branch decision (pc_write_cond & zero) is taken in the datapath.
    logic unused_zero;
    assign unused_zero = zero;

    assign state     = state_q;
    assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        bus_error     = 1'b0;
        instr_done    = 1'b0;
        state_d       = StFetch;
        // Ready in the limit cycle wins: timeout only fires with mem_ready low.
        timeout       = (wait_cnt_q == 8'(WAIT_LIMIT)) && !mem_ready;

        // All outputs are held at 0 while reset is asserted.
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = StDecode;
                    end else if (timeout) begin
                        bus_error = 1'b1;
                    end else begin
                        state_d = StFetch;
                    end
                end
                StDecode: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW:                      state_d = StMemAddr;
                        OP_R:                              state_d = StRExec;
                        OP_BEQ:                            state_d = StBranch;
                        OP_J:                              state_d = StJump;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = StIExec;
                        default: begin
                            illegal_op = 1'b1;
                            state_d    = StFetch;
                        end
                    endcase
                end
                StMemAddr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode == OP_LW) begin
                        state_d = StMemRd;
                    end else if (opcode == OP_SW) begin
                        state_d = StMemWr;
                    end
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) begin
                        state_d = StMemWb;
                    end else if (timeout) begin
                        bus_error = 1'b1;
                    end else begin
                        state_d = StMemRd;
                    end
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                    end else if (timeout) begin
                        bus_error = 1'b1;
                    end else begin
                        state_d = StMemWr;
                    end
                end
                StRExec: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'b010;
                    state_d   = StRWb;
                end
                StRWb: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                StBranch: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 3'b001;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                StJump: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                StIExec: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_ANDI: alu_op = 3'b011;
                        OP_ORI:  alu_op = 3'b100;
                        OP_XORI: alu_op = 3'b101;
                        default: alu_op = 3'b000;
                    endcase
                    state_d = StIWb;
                end
                StIWb: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StFetch;
            wait_cnt_q  <= 8'd0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            // Not ready and not timed out means the FSM stays put and keeps counting.
            // Every other case (ready, timeout, non-memory state) clears the counter,
            // so each entry into a memory state starts from zero.
            if (mem_state && !mem_ready && !bus_error) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end else begin
                wait_cnt_q <= 8'd0;
            end
            if (instr_done) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic [1:0]  pc_source;
    logic [3:0]  state;
    logic        illegal_op, bus_error, instr_done;
    logic [31:0] instr_count;

    multicycle_control_fsm #(
        .WAIT_LIMIT(4),
        .CNT_W     (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .state        (state),
        .illegal_op   (illegal_op),
        .bus_error    (bus_error),
        .instr_done   (instr_done),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    // Observed control word:
    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
    //  reg_write, alu_src_a} {alu_src_b} {alu_op} {pc_source} {illegal_op, bus_error, instr_done}
    logic [19:0] ctl;
    assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
                  bus_error, instr_done};

    localparam logic [19:0] C_FETCH_W = {10'b0001000000, 2'b01, 3'b000, 2'b00, 3'b000};
    localparam logic [19:0] C_FETCH_R = {10'b1001010000, 2'b01, 3'b000, 2'b00, 3'b000};
    localparam logic [19:0] C_DECODE  = {10'b0000000000, 2'b11, 3'b000, 2'b00, 3'b000};
    localparam logic [19:0] C_ILLEGAL = {10'b0000000000, 2'b11, 3'b000, 2'b00, 3'b100};
    localparam logic [19:0] C_MADDR   = {10'b0000000001, 2'b10, 3'b000, 2'b00, 3'b000};
    localparam logic [19:0] C_MRD     = {10'b0011000000, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam logic [19:0] C_MWB     = {10'b0000001010, 2'b00, 3'b000, 2'b00, 3'b001};
    localparam logic [19:0] C_MWR_W   = {10'b0010100000, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam logic [19:0] C_MWR_R   = {10'b0010100000, 2'b00, 3'b000, 2'b00, 3'b001};
    localparam logic [19:0] C_REXEC   = {10'b0000000001, 2'b00, 3'b010, 2'b00, 3'b000};
    localparam logic [19:0] C_RWB     = {10'b0000000110, 2'b00, 3'b000, 2'b00, 3'b001};
    localparam logic [19:0] C_BRANCH  = {10'b0100000001, 2'b00, 3'b001, 2'b01, 3'b001};
    localparam logic [19:0] C_JUMP    = {10'b1000000000, 2'b00, 3'b000, 2'b10, 3'b001};
    localparam logic [19:0] C_IEXEC   = {10'b0000000001, 2'b10, 3'b000, 2'b00, 3'b000};
    localparam logic [19:0] C_IWB     = {10'b0000000010, 2'b00, 3'b000, 2'b00, 3'b001};
    localparam logic [19:0] C_BUSERR  = 20'h00002;

    typedef struct {
        logic [3:0]  st;
        logic [19:0] ctl;
        logic        rdy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Scoreboard entry: mem_ready to drive this cycle and the outputs it must produce.
    task automatic push(input logic [3:0] st, input logic [19:0] c, input logic rdy);
        exp_t e;
        e.st  = st;
        e.ctl = c;
        e.rdy = rdy;
        sb.push_back(e);
    endtask

    // Drive one cycle's mem_ready at the falling edge and settle before sampling.
    task automatic step(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        #2;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'h23;
        repeat (2) @(negedge clk);
        #2;
        n_cmp++;
        if (state !== 4'd0 || ctl !== 20'h0 || instr_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset: state=%0d ctrl=%05h count=%0d, required state=0 ctrl=00000 count=0",
                     state, ctl, instr_count);
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_r_type();
        exp_t e;
        opcode = 6'h00;
        push(4'd0, C_FETCH_R, 1'b1);
        push(4'd1, C_DECODE, 1'b0);
        push(4'd6, C_REXEC, 1'b0);
        push(4'd7, C_RWB, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.rdy);
            n_cmp++;
            if (state !== e.st || ctl !== e.ctl) begin
                n_err++;
                $display("FAIL r_type: state=%0d ctrl=%05h, required state=%0d ctrl=%05h",
                         state, ctl, e.st, e.ctl);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (state !== 4'd0 || instr_count !== 32'd1) begin
            n_err++;
            $display("FAIL r_type_end: state=%0d count=%0d, required state=0 count=1",
                     state, instr_count);
        end
    endtask

    task automatic test_lw_wait();
        exp_t e;
        opcode = 6'h23;
        push(4'd0, C_FETCH_R, 1'b1);
        push(4'd1, C_DECODE, 1'b0);
        push(4'd2, C_MADDR, 1'b0);
        for (int i = 0; i < 3; i++) push(4'd3, C_MRD, 1'b0);
        push(4'd3, C_MRD, 1'b1);
        push(4'd4, C_MWB, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.rdy);
            n_cmp++;
            if (state !== e.st || ctl !== e.ctl) begin
                n_err++;
                $display("FAIL lw_wait: state=%0d ctrl=%05h, required state=%0d ctrl=%05h",
                         state, ctl, e.st, e.ctl);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (instr_count !== 32'd2) begin
            n_err++;
            $display("FAIL lw_count: count=%0d, required 2", instr_count);
        end
    endtask

    task automatic test_sw();
        exp_t e;
        opcode = 6'h2B;
        push(4'd0, C_FETCH_R, 1'b1);
        push(4'd1, C_DECODE, 1'b0);
        push(4'd2, C_MADDR, 1'b0);
        push(4'd5, C_MWR_W, 1'b0);
        push(4'd5, C_MWR_R, 1'b1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.rdy);
            n_cmp++;
            if (state !== e.st || ctl !== e.ctl) begin
                n_err++;
                $display("FAIL sw: state=%0d ctrl=%05h, required state=%0d ctrl=%05h",
                         state, ctl, e.st, e.ctl);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (instr_count !== 32'd3) begin
            n_err++;
            $display("FAIL sw_count: count=%0d, required 3", instr_count);
        end
    endtask

    task automatic test_branch();
        exp_t e;
        opcode = 6'h04;
        zero   = 1'b1;
        push(4'd0, C_FETCH_R, 1'b1);
        push(4'd1, C_DECODE, 1'b0);
        push(4'd8, C_BRANCH, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.rdy);
            n_cmp++;
            if (state !== e.st || ctl !== e.ctl) begin
                n_err++;
                $display("FAIL beq: state=%0d ctrl=%05h, required state=%0d ctrl=%05h",
                         state, ctl, e.st, e.ctl);
            end
        end
        zero = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (instr_count !== 32'd4) begin
            n_err++;
            $display("FAIL beq_count: count=%0d, required 4", instr_count);
        end
    endtask

    task automatic test_jump();
        exp_t e;
        opcode = 6'h02;
        push(4'd0, C_FETCH_R, 1'b1);
        push(4'd1, C_DECODE, 1'b0);
        push(4'd9, C_JUMP, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.rdy);
            n_cmp++;
            if (state !== e.st || ctl !== e.ctl) begin
                n_err++;
                $display("FAIL jump: state=%0d ctrl=%05h, required state=%0d ctrl=%05h",
                         state, ctl, e.st, e.ctl);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (instr_count !== 32'd5) begin
            n_err++;
            $display("FAIL jump_count: count=%0d, required 5", instr_count);
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        opcode = 6'h3F;
        push(4'd0, C_FETCH_R, 1'b1);
        push(4'd1, C_ILLEGAL, 1'b0);
        push(4'd0, C_FETCH_W, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.rdy);
            n_cmp++;
            if (state !== e.st || ctl !== e.ctl) begin
                n_err++;
                $display("FAIL illegal: state=%0d ctrl=%05h, required state=%0d ctrl=%05h",
                         state, ctl, e.st, e.ctl);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (instr_count !== 32'd5) begin
            n_err++;
            $display("FAIL illegal_count: count=%0d, required 5", instr_count);
        end
    endtask

    task automatic test_i_type();
        exp_t       e;
        logic [5:0] ops[4];
        logic [2:0] aops[4];
        ops  = '{6'h08, 6'h0C, 6'h0D, 6'h0E};
        aops = '{3'b000, 3'b011, 3'b100, 3'b101};
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            push(4'd0, C_FETCH_R, 1'b1);
            push(4'd1, C_DECODE, 1'b0);
            push(4'd10, C_IEXEC | {12'd0, aops[k], 5'd0}, 1'b0);
            push(4'd11, C_IWB, 1'b0);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                step(e.rdy);
                n_cmp++;
                if (state !== e.st || ctl !== e.ctl) begin
                    n_err++;
                    $display("FAIL i_type op=%02h: state=%0d ctrl=%05h, required state=%0d ctrl=%05h",
                             ops[k], state, ctl, e.st, e.ctl);
                end
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (instr_count !== 32'd9) begin
            n_err++;
            $display("FAIL i_type_count: count=%0d, required 9", instr_count);
        end
    endtask

    task automatic test_bus_error();
        exp_t e;
        opcode = 6'h00;
        // Fetch timeout: four waits, error on the fifth cycle, then retry from a clean count.
        for (int i = 0; i < 4; i++) push(4'd0, C_FETCH_W, 1'b0);
        push(4'd0, C_FETCH_W | C_BUSERR, 1'b0);
        // Ready arriving in the limit cycle completes normally.
        for (int i = 0; i < 4; i++) push(4'd0, C_FETCH_W, 1'b0);
        push(4'd0, C_FETCH_R, 1'b1);
        push(4'd1, C_DECODE, 1'b0);
        push(4'd6, C_REXEC, 1'b0);
        push(4'd7, C_RWB, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.rdy);
            n_cmp++;
            if (state !== e.st || ctl !== e.ctl) begin
                n_err++;
                $display("FAIL bus_error_fetch: state=%0d ctrl=%05h, required state=%0d ctrl=%05h",
                         state, ctl, e.st, e.ctl);
            end
        end
        // Load that times out in MEM_RD: no writeback, nothing retired.
        opcode = 6'h23;
        push(4'd0, C_FETCH_R, 1'b1);
        push(4'd1, C_DECODE, 1'b0);
        push(4'd2, C_MADDR, 1'b0);
        for (int i = 0; i < 4; i++) push(4'd3, C_MRD, 1'b0);
        push(4'd3, C_MRD | C_BUSERR, 1'b0);
        push(4'd0, C_FETCH_W, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.rdy);
            n_cmp++;
            if (state !== e.st || ctl !== e.ctl) begin
                n_err++;
                $display("FAIL bus_error_memrd: state=%0d ctrl=%05h, required state=%0d ctrl=%05h",
                         state, ctl, e.st, e.ctl);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (instr_count !== 32'd10) begin
            n_err++;
            $display("FAIL bus_error_count: count=%0d, required 10", instr_count);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        opcode = 6'h00;
        push(4'd0, C_FETCH_R, 1'b1);
        push(4'd1, C_DECODE, 1'b0);
        push(4'd6, C_REXEC, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.rdy);
            n_cmp++;
            if (state !== e.st || ctl !== e.ctl) begin
                n_err++;
                $display("FAIL reset_mid_pre: state=%0d ctrl=%05h, required state=%0d ctrl=%05h",
                         state, ctl, e.st, e.ctl);
            end
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (state !== 4'd0 || ctl !== 20'h0 || instr_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_async: state=%0d ctrl=%05h count=%0d, required 0/00000/0",
                     state, ctl, instr_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(4'd0, C_FETCH_W, 1'b0);
        push(4'd0, C_FETCH_W, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.rdy);
            n_cmp++;
            if (state !== e.st || ctl !== e.ctl) begin
                n_err++;
                $display("FAIL reset_mid_post: state=%0d ctrl=%05h, required state=%0d ctrl=%05h",
                         state, ctl, e.st, e.ctl);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (instr_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_count: count=%0d, required 0", instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jump();
        test_illegal();
        test_i_type();
        test_bus_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at time 100000, required completion earlier");
        $fatal(1);
    end

endmodule
